// File: rtl/siso_shift_sequencer.sv
// Loopback sequencer for an external SISO shift-register chain: serializes a
// parallel word into D, flushes the chain, reassembles Q and flags mismatches.
module siso_shift_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_d,
  output logic             sr_en,
  input  logic             sr_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic             busy
);

  localparam int unsigned TOTAL = WIDTH + DEPTH;
  localparam int unsigned KW    = $clog2(TOTAL + 1);
  localparam int unsigned PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] cap_q;
  logic [KW-1:0]    k_q;
  logic             in_ready_q;
  logic             sr_d_q;
  logic             sr_en_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             err_q;
  logic             busy_q;

  logic [KW-1:0]    k_d;
  logic [KW-1:0]    ret_idx;
  logic [WIDTH-1:0] cap_d;
  logic             next_bit;
  logic             first_bit;
  logic             last_k;

  // Word bit position of serial slot idx; same mapping for send and capture.
  function automatic logic [PW-1:0] order_pos(input logic [KW-1:0] idx);
    logic [KW-1:0] p;
    if (MSB_FIRST) p = KW'(WIDTH - 1) - idx;
    else           p = idx;
    return p[PW-1:0];
  endfunction

  always_comb begin
    k_d       = k_q + KW'(1);
    ret_idx   = k_q - KW'(DEPTH);
    last_k    = (k_q == KW'(TOTAL - 1));
    first_bit = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    next_bit  = 1'b0;
    if (k_d < KW'(WIDTH)) next_bit = word_q[order_pos(k_d)];
    cap_d = cap_q;
    if (k_q >= KW'(DEPTH)) cap_d[order_pos(ret_idx)] = sr_q;
  end

  // sr_d for slot k is registered at the edge ending slot k-1 (or the accept edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      cap_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      sr_d_q      <= 1'b0;
      sr_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            word_q     <= in_data;
            cap_q      <= '0;
            k_q        <= '0;
            sr_d_q     <= first_bit;
            sr_en_q    <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          cap_q <= cap_d;
          if (last_k) begin
            sr_en_q     <= 1'b0;
            sr_d_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= cap_d;
            err_q       <= (cap_d != word_q);
            state_q     <= DONE;
          end else begin
            k_q    <= k_d;
            sr_d_q <= next_bit;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          sr_en_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign sr_d      = sr_d_q;
  assign sr_en     = sr_en_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
